// File: rtl/unit_control_pkg.sv
// Shared encodings for the unit_control decoder: op/cmd fields, ALU control,
// condition codes and flag-write masks.
package unit_control_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // FlagW bit 1 enables the NZ pair, bit 0 enables the CV pair.
  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

  function automatic logic cond_check(
    input logic [3:0] cond,
    input logic       n,
    input logic       z,
    input logic       c,
    input logic       v
  );
    logic ok;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// Stored NZCV flags and condition evaluation; the condition only ever looks
// at the stored flags, so a failed instruction cannot update them.
module cond_logic
  import unit_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [1:0] i_flag_w,
  input  logic       i_negative,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_overflow,
  output logic       o_cond_ex
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_cond_ex;

  assign w_cond_ex = cond_check(i_cond, r_nz[1], r_nz[0], r_cv[1], r_cv[0]);
  assign o_cond_ex = w_cond_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (i_flag_w[1] && w_cond_ex) r_nz <= {i_negative, i_zero};
      if (i_flag_w[0] && w_cond_ex) r_cv <= {i_carry, i_overflow};
    end
  end

endmodule

// File: rtl/unit_control.sv
// Instruction control unit: inline main/ALU decoders plus cond_logic gating
// of the state-changing outputs.
module unit_control
  import unit_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] OP,
  input  logic [5:0] Funct,
  input  logic [3:0] RD,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Carry,
  input  logic       Overflow,
  output logic       PCSrc,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  logic       w_branch;
  logic       w_mem_w;
  logic       w_reg_w;
  logic       w_alu_op;
  logic       w_mem_to_reg;
  logic       w_alu_src;
  logic [1:0] w_reg_src;
  logic [1:0] w_imm_src;
  alu_ctrl_e  w_alu_ctrl;
  logic [1:0] w_flag_w;
  logic       w_pcs;
  logic       w_cond_ex;
  logic [3:0] w_cmd;
  logic       w_s_bit;

  assign w_cmd   = Funct[4:1];
  assign w_s_bit = Funct[0];

  always_comb begin
    w_branch     = 1'b0;
    w_mem_w      = 1'b0;
    w_reg_w      = 1'b0;
    w_alu_op     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_src    = 2'b00;
    w_imm_src    = 2'b00;
    case (OP)
      OP_DP: begin
        w_reg_w   = 1'b1;
        w_alu_op  = 1'b1;
        w_alu_src = Funct[5];
      end
      OP_MEM: begin
        w_alu_src = 1'b1;
        w_imm_src = 2'b01;
        // Funct[0] is L here: load writes the register file, store writes memory.
        if (Funct[0]) begin
          w_mem_to_reg = 1'b1;
          w_reg_w      = 1'b1;
        end else begin
          w_mem_w   = 1'b1;
          w_reg_src = 2'b10;
        end
      end
      OP_BR: begin
        w_branch  = 1'b1;
        w_alu_src = 1'b1;
        w_imm_src = 2'b10;
        w_reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_flag_w   = FLAGW_NONE;
    if (w_alu_op) begin
      case (w_cmd)
        CMD_ADD: begin
          w_alu_ctrl = ALU_ADD;
          w_flag_w   = w_s_bit ? FLAGW_ALL : FLAGW_NONE;
        end
        CMD_SUB: begin
          w_alu_ctrl = ALU_SUB;
          w_flag_w   = w_s_bit ? FLAGW_ALL : FLAGW_NONE;
        end
        CMD_AND: begin
          w_alu_ctrl = ALU_AND;
          w_flag_w   = w_s_bit ? FLAGW_NZ : FLAGW_NONE;
        end
        CMD_ORR: begin
          w_alu_ctrl = ALU_ORR;
          w_flag_w   = w_s_bit ? FLAGW_NZ : FLAGW_NONE;
        end
        default: begin
          w_alu_ctrl = ALU_ADD;
          w_flag_w   = FLAGW_NONE;
        end
      endcase
    end
  end

  // Writing R15 through a normal register write is also a PC change.
  assign w_pcs = w_branch | ((RD == 4'b1111) & w_reg_w);

  cond_logic u_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cond     (Cond),
    .i_flag_w   (w_flag_w),
    .i_negative (Negative),
    .i_zero     (Zero),
    .i_carry    (Carry),
    .i_overflow (Overflow),
    .o_cond_ex  (w_cond_ex)
  );

  assign PCSrc      = w_pcs & w_cond_ex;
  assign RegWrite   = w_reg_w & w_cond_ex;
  assign MemWrite   = w_mem_w & w_cond_ex;
  assign MemtoReg   = w_mem_to_reg;
  assign ALUSrc     = w_alu_src;
  assign RegSrc     = w_reg_src;
  assign ImmSrc     = w_imm_src;
  assign ALUControl = w_alu_ctrl;

endmodule

// File: tb/tb_unit_control.sv
// Bench for unit_control: directed scenarios then random instructions, all
// compared against a flag-tracking reference model.
module tb_unit_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] OP;
  logic [5:0] Funct;
  logic [3:0] RD;
  logic       Zero, Negative, Carry, Overflow;
  logic       PCSrc, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0] RegSrc, ImmSrc, ALUControl;

  int n_chk  = 0;
  int n_fail = 0;
  logic m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

  always #5 clk = ~clk;

  unit_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .OP         (OP),
    .Funct      (Funct),
    .RD         (RD),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .PCSrc      (PCSrc),
    .MemtoReg   (MemtoReg),
    .MemWrite   (MemWrite),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_cond(input logic [3:0] c);
    logic ok;
    ok = 1'b0;
    if      (c == 4'd0)  ok = m_z;
    else if (c == 4'd1)  ok = !m_z;
    else if (c == 4'd2)  ok = m_c;
    else if (c == 4'd3)  ok = !m_c;
    else if (c == 4'd4)  ok = m_n;
    else if (c == 4'd5)  ok = !m_n;
    else if (c == 4'd6)  ok = m_v;
    else if (c == 4'd7)  ok = !m_v;
    else if (c == 4'd8)  ok = m_c && !m_z;
    else if (c == 4'd9)  ok = !m_c || m_z;
    else if (c == 4'd10) ok = (m_n == m_v);
    else if (c == 4'd11) ok = (m_n != m_v);
    else if (c == 4'd12) ok = !m_z && (m_n == m_v);
    else if (c == 4'd13) ok = m_z || (m_n != m_v);
    else if (c == 4'd14) ok = 1'b1;
    return ok;
  endfunction

  // Expected outputs packed {PCSrc,MemtoReg,MemWrite,ALUSrc,RegWrite,RegSrc,ImmSrc,ALUControl}.
  task automatic model(output logic [10:0] e, output logic [1:0] fw);
    logic br, mw, rw, mtr, asrc, aop, ce, pcs;
    logic [1:0] rs, is, ac;
    int cmd;
    {br, mw, rw, mtr, asrc, aop} = 6'b0;
    rs = 2'd0; is = 2'd0; ac = 2'd0; fw = 2'd0;
    if (OP == 2'd0) begin
      rw = 1; aop = 1; asrc = Funct[5];
    end else if (OP == 2'd1 && Funct[0]) begin
      mtr = 1; rw = 1; asrc = 1; is = 2'd1;
    end else if (OP == 2'd1) begin
      mw = 1; asrc = 1; is = 2'd1; rs = 2'd2;
    end else if (OP == 2'd2) begin
      br = 1; asrc = 1; is = 2'd2; rs = 2'd1;
    end
    cmd = int'(Funct[4:1]);
    if (aop) begin
      if (cmd == 4)       begin ac = 2'd0; fw = Funct[0] ? 2'd3 : 2'd0; end
      else if (cmd == 2)  begin ac = 2'd1; fw = Funct[0] ? 2'd3 : 2'd0; end
      else if (cmd == 0)  begin ac = 2'd2; fw = Funct[0] ? 2'd2 : 2'd0; end
      else if (cmd == 12) begin ac = 2'd3; fw = Funct[0] ? 2'd2 : 2'd0; end
    end
    ce  = model_cond(Cond);
    pcs = br || (RD == 4'd15 && rw);
    e = {pcs && ce, mtr, mw && ce, asrc, rw && ce, rs, is, ac};
  endtask

  task automatic check_outputs(input string pfx);
    logic [10:0] e;
    logic [1:0]  fw;
    model(e, fw);
    chk({pfx, ".PCSrc"},      32'(PCSrc),      32'(e[10]));
    chk({pfx, ".MemtoReg"},   32'(MemtoReg),   32'(e[9]));
    chk({pfx, ".MemWrite"},   32'(MemWrite),   32'(e[8]));
    chk({pfx, ".ALUSrc"},     32'(ALUSrc),     32'(e[7]));
    chk({pfx, ".RegWrite"},   32'(RegWrite),   32'(e[6]));
    chk({pfx, ".RegSrc"},     32'(RegSrc),     32'(e[5:4]));
    chk({pfx, ".ImmSrc"},     32'(ImmSrc),     32'(e[3:2]));
    chk({pfx, ".ALUControl"}, 32'(ALUControl), 32'(e[1:0]));
  endtask

  task automatic check_flags(input string pfx);
    chk({pfx, ".flags"}, 32'({dut.u_cond.r_nz, dut.u_cond.r_cv}), 32'({m_n, m_z, m_c, m_v}));
  endtask

  task automatic apply(input string tag, input logic [3:0] c, input logic [1:0] op,
                       input logic [5:0] f, input logic [3:0] rd,
                       input logic z, input logic n, input logic cy, input logic v);
    logic [10:0] e;
    logic [1:0]  fw;
    logic        ce;
    Cond = c; OP = op; Funct = f; RD = rd;
    Zero = z; Negative = n; Carry = cy; Overflow = v;
    @(negedge clk);
    check_outputs(tag);
    model(e, fw);
    ce = model_cond(Cond);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      {m_n, m_z, m_c, m_v} = 4'b0;
    end else begin
      if (fw[1] && ce) {m_n, m_z} = {n, z};
      if (fw[0] && ce) {m_c, m_v} = {cy, v};
    end
    check_flags(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    Cond = 4'b0000; OP = 2'b00; Funct = 6'b001001; RD = 4'd0;
    {Zero, Negative, Carry, Overflow} = 4'b1111;
    #2;
    chk("rst.RegWrite", 32'(RegWrite), 32'(1'b0));
    check_flags("rst");
    // Flag-setting instruction while held in reset must not load anything.
    apply("rst_hold", 4'hE, 2'd0, 6'b001001, 4'h5, 1, 1, 1, 1);
    @(negedge clk);
    rst_n = 1'b1;

    apply("flag_set",  4'hE, 2'd0, 6'b001001, 4'h5, 1, 0, 0, 0);
    chk("flag_set.Z", 32'(m_z), 32'(1'b1));
    apply("eq_pass",   4'h0, 2'd0, 6'b001001, 4'h5, 0, 0, 0, 0);
    apply("eq_fail",   4'h0, 2'd0, 6'b001000, 4'h5, 1, 1, 1, 1);
    apply("pc_rd8",    4'hE, 2'd0, 6'b000101, 4'h8, 1, 0, 1, 0);
    apply("pc_rd15",   4'hE, 2'd0, 6'b000101, 4'hF, 1, 0, 1, 0);
    apply("str",       4'hE, 2'd1, 6'b011000, 4'h3, 0, 0, 0, 0);
    apply("ldr",       4'hE, 2'd1, 6'b011001, 4'h3, 0, 0, 0, 0);
    apply("set_nv",    4'hE, 2'd0, 6'b001001, 4'h5, 0, 1, 0, 0);
    apply("b_lt",      4'hB, 2'd2, 6'b000000, 4'h0, 0, 0, 0, 0);
    chk("b_lt.PCSrc_direct", 32'(PCSrc), 32'(1'b1));
    apply("b_nv",      4'hF, 2'd2, 6'b000000, 4'h0, 0, 0, 0, 0);
    apply("op11",      4'hE, 2'd3, 6'b111111, 4'hF, 1, 1, 1, 1);

    // Asynchronous reset with an update pending must clear and discard it.
    Cond = 4'hE; OP = 2'd0; Funct = 6'b001001; RD = 4'h1;
    {Zero, Negative, Carry, Overflow} = 4'b1111;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    {m_n, m_z, m_c, m_v} = 4'b0;
    check_flags("async_rst");
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_flags("async_rst_edge");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      logic [3:0] rd;
      f  = 6'($urandom);
      if ($urandom_range(0, 1) == 0) f[4:1] = (4'($urandom_range(0, 3)) == 4'd0) ? 4'b0100 :
                                               (4'($urandom_range(0, 2)) == 4'd0) ? 4'b0010 :
                                               ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1100;
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      apply("rand", 4'($urandom), 2'($urandom), f, rd,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
